// File: rtl/array_allocator.sv
// array_allocator: shared array-handle allocator for the generated-program runtime.
// Hands out handles from a LIFO free-list (reused first, otherwise freshly minted).
// Keeps a per-array length table and a sticky misuse flag.
// Optional feature: define ARRAY_ALLOCATOR_STATS_EN to add the inUse / peakInUse counters.
module array_allocator #(
    parameter int unsigned NArrays            = 16,
    parameter int unsigned MemoryElementWidth = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          allocValid,
    output logic                          allocReady,
    output logic [MemoryElementWidth-1:0] allocHandle,
    output logic                          allocDone,
    input  logic                          freeValid,
    input  logic [MemoryElementWidth-1:0] freeHandle,
    output logic                          freeReady,
    input  logic                          sizeWrite,
    input  logic [MemoryElementWidth-1:0] sizeHandle,
    input  logic [MemoryElementWidth-1:0] sizeIndex,
    output logic [MemoryElementWidth-1:0] sizeOut,
    output logic [MemoryElementWidth-1:0] allocs,
    output logic                          error,
    output logic [1:0]                    errorCode
`ifdef ARRAY_ALLOCATOR_STATS_EN
    ,
    output logic [MemoryElementWidth-1:0] inUse,
    output logic [MemoryElementWidth-1:0] peakInUse
`endif
);
    localparam int unsigned IdxW = $clog2(NArrays);
    localparam int unsigned TopW = IdxW + 1;
    localparam int unsigned W    = MemoryElementWidth;
    localparam logic [W-1:0]    NArraysW = W'(NArrays);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NArrays - 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     init_cnt_q, init_cnt_d;
    logic [TopW-1:0]     free_top_q, free_top_d;
    logic [IdxW-1:0]     free_list_q [NArrays];
    logic [W-1:0]        len_q [NArrays];
    logic [NArrays-1:0]  in_use_q, in_use_d;
    logic [W-1:0]        allocs_q, allocs_d;
    logic                error_q, error_d;
    logic [1:0]          code_q, code_d;

    logic                run;
    logic [IdxW-1:0]     free_idx, size_idx, pop_idx, grant_idx;
    logic                free_in_range, size_in_range;
    logic                free_legal, alloc_ready, alloc_fire;
    logic                pop, push, mint;
    logic                size_upd;
    logic [W-1:0]        size_new;
    logic                err_hit;
    logic [1:0]          err_code;

    // Request decode: legality of free / size write and how an accepted alloc is served.
    always_comb begin
        run           = (state_q == StRun);
        free_idx      = freeHandle[IdxW-1:0];
        size_idx      = sizeHandle[IdxW-1:0];
        pop_idx       = free_top_q[IdxW-1:0] - IdxW'(1);
        free_in_range = (freeHandle < allocs_q);
        size_in_range = (sizeHandle < allocs_q);
        // Only a legal free can be bypassed; an erroneous free has no effect at all.
        free_legal    = run && freeValid && free_in_range && in_use_q[free_idx];
        alloc_ready   = run && ((free_top_q != '0) || (allocs_q < NArraysW) || free_legal);
        alloc_fire    = allocValid && alloc_ready;
        pop           = alloc_fire && !free_legal && (free_top_q != '0);
        mint          = alloc_fire && !free_legal && (free_top_q == '0);
        push          = free_legal && !alloc_fire;
        if (free_legal) begin
            grant_idx = free_idx;
        end else if (pop) begin
            grant_idx = free_list_q[pop_idx];
        end else begin
            grant_idx = allocs_q[IdxW-1:0];
        end
        size_new = sizeIndex + W'(1);
        // A free of the same handle in this cycle wins over the length update.
        size_upd = run && sizeWrite && size_in_range && in_use_q[size_idx]
                   && !(free_legal && (free_idx == size_idx));
    end

    // Misuse classification; free errors take priority over size-write errors.
    always_comb begin
        err_hit  = 1'b1;
        err_code = 2'd0;
        if (run && freeValid && !free_in_range) begin
            err_code = 2'd2;
        end else if (run && freeValid && !in_use_q[free_idx]) begin
            err_code = 2'd1;
        end else if (run && sizeWrite && !size_in_range) begin
            err_code = 2'd2;
        end else if (run && sizeWrite && !in_use_q[size_idx]) begin
            err_code = 2'd3;
        end else begin
            err_hit = 1'b0;
        end
    end

    // Next-state: INIT sweep, then bitmap / free-list / counter updates in RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        free_top_d = free_top_q;
        in_use_d   = in_use_q;
        allocs_d   = allocs_q;
        error_d    = error_q;
        code_d     = code_q;
        case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + IdxW'(1);
                if (init_cnt_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            default: begin
                // Clear before set so a bypassed handle stays live.
                if (free_legal) in_use_d[free_idx] = 1'b0;
                if (alloc_fire) in_use_d[grant_idx] = 1'b1;
                if (mint) allocs_d = allocs_q + W'(1);
                if (pop) begin
                    free_top_d = free_top_q - TopW'(1);
                end else if (push) begin
                    free_top_d = free_top_q + TopW'(1);
                end
                if (err_hit && !error_q) begin
                    error_d = 1'b1;
                    code_d  = err_code;
                end
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            free_top_q  <= '0;
            in_use_q    <= '0;
            allocs_q    <= '0;
            error_q     <= 1'b0;
            code_q      <= 2'd0;
            allocDone   <= 1'b0;
            allocHandle <= '0;
            sizeOut     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            free_top_q <= free_top_d;
            in_use_q   <= in_use_d;
            allocs_q   <= allocs_d;
            error_q    <= error_d;
            code_q     <= code_d;
            allocDone  <= alloc_fire;
            if (alloc_fire) begin
                allocHandle <= W'(grant_idx);
            end
            // Pre-update length of the queried handle.
            sizeOut <= (run && (sizeHandle < NArraysW)) ? len_q[size_idx] : '0;
        end
    end

    // Length table and free-list storage; the table is cleared by the INIT sweep, not by reset.
    always_ff @(posedge clock) begin
        if (state_q == StInit) begin
            len_q[init_cnt_q] <= '0;
        end else begin
            if (size_upd && (size_new > len_q[size_idx])) len_q[size_idx] <= size_new;
            if (free_legal) len_q[free_idx] <= '0;
            if (alloc_fire) len_q[grant_idx] <= '0;
            if (push) free_list_q[free_top_q[IdxW-1:0]] <= free_idx;
        end
    end

    assign allocReady = alloc_ready;
    assign freeReady  = run;
    assign allocs     = allocs_q;
    assign error      = error_q;
    assign errorCode  = code_q;

`ifdef ARRAY_ALLOCATOR_STATS_EN
    logic [W-1:0] in_use_cnt_q, in_use_cnt_d, peak_q;

    // Live-handle count; a bypassed alloc+free leaves it unchanged.
    always_comb begin
        in_use_cnt_d = in_use_cnt_q;
        if (alloc_fire && !free_legal) begin
            in_use_cnt_d = in_use_cnt_q + W'(1);
        end else if (free_legal && !alloc_fire) begin
            in_use_cnt_d = in_use_cnt_q - W'(1);
        end
    end

    // Occupancy counter and its high-water mark.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_use_cnt_q <= '0;
            peak_q       <= '0;
        end else begin
            in_use_cnt_q <= in_use_cnt_d;
            if (in_use_cnt_d > peak_q) peak_q <= in_use_cnt_d;
        end
    end

    assign inUse     = in_use_cnt_q;
    assign peakInUse = peak_q;
`endif

endmodule
